// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-drive, response and statistics signals of alu_issue_ctrl.
// The slave modport is the controller's view; master is the surrounding logic.
interface alu_issue_ctrl_if;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqA;
    logic [31:0] reqB;
    logic [3:0]  reqOp;
    logic [3:0]  reqTag;

    logic [31:0] aluA;
    logic [31:0] aluB;
    logic [3:0]  aluOp;
    logic        aluEn;
    logic [31:0] aluResult;
    logic        aluZero;

    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspResult;
    logic        rspZero;
    logic [3:0]  rspTag;
    logic        rspError;

    logic        busy;
    logic [31:0] issueCount;
    logic [15:0] errorCount;
    logic [31:0] stallCycles;

    modport slave (
        input  reqValid, reqA, reqB, reqOp, reqTag, aluResult, aluZero, rspReady,
        output reqReady, aluA, aluB, aluOp, aluEn,
        output rspValid, rspResult, rspZero, rspTag, rspError,
        output busy, issueCount, errorCount, stallCycles
    );

    modport master (
        output reqValid, reqA, reqB, reqOp, reqTag, aluResult, aluZero, rspReady,
        input  reqReady, aluA, aluB, aluOp, aluEn,
        input  rspValid, rspResult, rspZero, rspTag, rspError,
        input  busy, issueCount, errorCount, stallCycles
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one request at a time to an external ALU and returns its result with the tag.
// Latency: 2+ALU_LATENCY cycles accept-to-response for legal ops, 1 cycle for illegal ops.
// Backpressure: response held until rspReady; a new request is accepted on the same edge.
module alu_issue_ctrl #(
    parameter int ALU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    alu_issue_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] OP_MAX = 4'd9;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  tag_q, tag_d;
    logic [1:0]  wait_q, wait_d;
    logic [31:0] res_q, res_d;
    logic        zero_q, zero_d;
    logic        err_q, err_d;
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic req_ready;
    logic accept;

    assign req_ready = (state_q == IDLE) || ((state_q == RESP) && bus.rspReady);
    assign accept    = bus.reqValid && req_ready;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        tag_d       = tag_q;
        wait_d      = wait_q;
        res_d       = res_q;
        zero_d      = zero_q;
        err_d       = err_q;
        issue_cnt_d = issue_cnt_q;
        err_cnt_d   = err_cnt_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            IDLE: ;
            ISSUE: begin
                state_d = WAIT;
                wait_d  = 2'(ALU_LATENCY - 1);
                if (issue_cnt_q != '1) issue_cnt_d = issue_cnt_q + 32'd1;
            end
            WAIT: begin
                if (wait_q != 2'd0) begin
                    wait_d = wait_q - 2'd1;
                end else begin
                    res_d   = bus.aluResult;
                    zero_d  = bus.aluZero;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (!bus.rspReady) begin
                    if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new accept overrides the IDLE return when the response drains on the same edge.
        if (accept) begin
            tag_d = bus.reqTag;
            if (bus.reqOp <= OP_MAX) begin
                a_d     = bus.reqA;
                b_d     = bus.reqB;
                op_d    = bus.reqOp;
                state_d = ISSUE;
            end else begin
                res_d   = 32'd0;
                zero_d  = 1'b0;
                err_d   = 1'b1;
                state_d = RESP;
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            tag_q       <= '0;
            wait_q      <= '0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            issue_cnt_q <= '0;
            err_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            tag_q       <= tag_d;
            wait_q      <= wait_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            issue_cnt_q <= issue_cnt_d;
            err_cnt_q   <= err_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.reqReady    = req_ready;
    assign bus.aluA        = a_q;
    assign bus.aluB        = b_q;
    assign bus.aluOp       = op_q;
    assign bus.aluEn       = (state_q == ISSUE);
    assign bus.rspValid    = (state_q == RESP);
    assign bus.rspResult   = res_q;
    assign bus.rspZero     = zero_q;
    assign bus.rspTag      = tag_q;
    assign bus.rspError    = err_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.issueCount  = issue_cnt_q;
    assign bus.errorCount  = err_cnt_q;
    assign bus.stallCycles = stall_cnt_q;
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter ALU_LATENCY, default 1, legal range 1-4: clock edges from the ALU's enable edge to a valid result.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port reqValid  input  1  upstream request valid.
REQ-005 SHALL have port reqReady  output  1  request accepted when reqValid && reqReady at a rising edge.
REQ-006 SHALL have port reqA / reqB  input  32 each  operands.
REQ-007 SHALL have port reqOp  input  4  ALU op code; ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLTU=6 SLL=7 SRL=8 SRA=9.
REQ-008 SHALL have port reqTag  input  4  opaque tag returned with the response.
REQ-009 SHALL have ports aluA / aluB  output  32 each, aluOp  output  4, aluEn  output  1; these drive the ALU.
REQ-010 SHALL have ports aluResult  input  32, aluZero  input  1; these come from the ALU.
REQ-011 SHALL have ports rspValid  output  1, rspReady  input  1, rspResult  output  32, rspZero  output  1, rspTag  output  4, rspError  output  1.
REQ-012 SHALL have ports busy  output  1, issueCount  output  32, errorCount  output  16, stallCycles  output  32.

Function
REQ-013 SHALL implement an FSM with states IDLE, ISSUE, WAIT and RESP; all outputs SHALL derive from registered state.
REQ-014 reqReady SHALL equal (state==IDLE) || (state==RESP && rspReady).
REQ-015 On accept of a legal op (reqOp<=9), the block SHALL latch A, B, op and tag, and go to ISSUE.
REQ-016 On accept of an illegal op (reqOp>9), the block SHALL go directly to RESP with rspError=1, rspResult=0, rspZero=0, and the tag latched; the ALU SHALL NOT be enabled.
REQ-017 In ISSUE (exactly one cycle), aluEn SHALL be 1 and aluA/aluB/aluOp SHALL present the latched values; next state SHALL be WAIT with waitCnt=ALU_LATENCY-1.
REQ-018 aluA/aluB/aluOp SHALL hold the latched values in all states; aluEn SHALL be 0 in every state except ISSUE.
REQ-019 In WAIT, if waitCnt!=0 the block SHALL decrement it; if waitCnt==0 it SHALL capture aluResult into rspResult and aluZero into rspZero, set rspError=0, and go to RESP.
REQ-020 Legal-op latency with ALU_LATENCY=1: accept edge in cycle 0, ISSUE in cycle 1, WAIT in cycle 2, rspValid=1 from cycle 3; general latency SHALL be 2+ALU_LATENCY cycles.
REQ-021 In RESP, rspValid SHALL be 1, and rspResult/rspZero/rspTag/rspError SHALL remain stable until rspReady=1.
REQ-022 On rspReady in RESP:
- with a simultaneous new accept, next state SHALL be ISSUE (legal op) or RESP with the new error response (illegal op);
- otherwise next state SHALL be IDLE.
REQ-023 busy SHALL be 1 whenever state!=IDLE.
REQ-024 issueCount SHALL increment once per ISSUE cycle and saturate at 0xFFFFFFFF.
REQ-025 errorCount SHALL increment once per illegal accept and saturate at 0xFFFF.
REQ-026 stallCycles SHALL increment each RESP cycle with rspReady=0 and saturate at 0xFFFFFFFF.
REQ-027 reqValid while not ready SHALL be ignored; request inputs SHALL be sampled only at the accept edge.

Reset
REQ-028 On reset=1 at a rising edge, the block SHALL enter IDLE regardless of state, and any in-flight operation SHALL be discarded with no response.
REQ-029 Reset values SHALL be:
- aluEn=0, rspValid=0, rspError=0, rspZero=0, busy=0;
- aluA=aluB=rspResult=0, aluOp=0, rspTag=0;
- all counters 0;
- reqReady=1 on the first non-reset cycle.

Verification
REQ-030 Accept ADD A=15, B=25, tag=3, rspReady=1 -> aluEn high for exactly 1 cycle, rspValid in cycle 3, rspResult=40, rspZero=0, rspTag=3, issueCount=1.
REQ-031 SUB A=100, B=100 with rspReady=0 for 5 cycles -> rspResult=0 and rspZero=1 held stable throughout, stallCycles=5, reqReady=0 during the stall.
REQ-032 reqOp=4'hC, tag=7 -> rspValid the cycle after accept, rspError=1, rspResult=0, aluEn never asserted, errorCount=1, issueCount unchanged.
REQ-033 Back-to-back: in RESP, rspReady=1 with SRA A=0x80000000, B=4 pending -> accepted that same edge, next response 0xF8000000, no IDLE cycle between.
REQ-034 reset asserted during WAIT -> next cycle state IDLE, rspValid=0, aluEn=0, counters 0, and no response emitted for the aborted op.
REQ-035 ALU_LATENCY=3, accept SLL A=1, B=4 -> rspValid in cycle 5, rspResult=16.
